sample_sequencer: RTL and testbench
===================================

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 CLK_50M  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 enable  in  1  1 = sample tick counter runs; 0 = counter held at 0, no new ticks.
REQ-004 period  in  16  sample period in CLK_50M cycles; values 0..1 treated as 2.
REQ-005 gain_in  in  8  requested preamp gain word.
REQ-006 amp_req  out  1  level request to preamp SPI driver; amp_gain  out  8  gain word; amp_done  in  1  one-cycle completion pulse.
REQ-007 adc_start  out  1  one-cycle AD_CONV pulse; adc_done  in  1  one-cycle capture-complete pulse; adc_data  in  28  {Va[13:0], Vb[13:0]}, two's complement.
REQ-008 dac_req  out  1  level request to DAC driver; dac_sel  out  1  0 = channel A, 1 = channel B; dac_data  out  12  DAC code; dac_done  in  1  one-cycle completion pulse.
REQ-009 dac_b_in  in  14  processed sample for DAC B, two's complement, sampled at DAC_B entry.
REQ-010 spi_owner  out  2  shared SPI bus grant: 00 none, 01 preamp, 10 ADC, 11 DAC.
REQ-011 sample_va, sample_vb  out  14 each  last captured samples; sample_valid  out  1  one-cycle pulse when updated.
REQ-012 busy  out  1  1 when FSM not IDLE; overrun  out  1  sticky dropped-tick flag; timeout  out  1  sticky watchdog flag.

Function
REQ-013 Tick counter SHALL count 0..P-1 (P = effective period), asserting internal tick for one cycle when count = P-1, then wrapping to 0.
REQ-014 FSM states SHALL be IDLE, AMP, CONV, ADC_WAIT, DAC_A, DAC_B; one state register, encoding free.
REQ-015 IDLE: on tick, if gain_in != gain_cur go to AMP, else go to CONV; no tick -> stay.
REQ-016 AMP: amp_req = 1, amp_gain = gain_in latched at entry, spi_owner = 01; on amp_done set gain_cur <= latched gain and go to CONV.
REQ-017 CONV: adc_start = 1 for exactly one cycle, spi_owner = 10, next state ADC_WAIT.
REQ-018 ADC_WAIT: spi_owner = 10; on adc_done latch sample_va/sample_vb from adc_data, pulse sample_valid the following cycle, and go to DAC_A.
REQ-019 DAC_A: dac_req = 1, dac_sel = 0, dac_data = {~Va[13], Va[12:2]} (offset-binary, top 12 bits), spi_owner = 11; on dac_done go to DAC_B.
REQ-020 DAC_B: dac_req = 1, dac_sel = 1, dac_data = {~B[13], B[12:2]} with B = dac_b_in captured at state entry and held, spi_owner = 11; on dac_done go to IDLE.
REQ-021 In IDLE spi_owner SHALL be 00 and amp_req, adc_start and dac_req SHALL be 0; at most one of the three SHALL be active in any cycle.
REQ-022 A tick arriving when FSM is not IDLE SHALL be dropped and overrun SHALL be set; the sequence in progress SHALL NOT be disturbed.
REQ-023 A tick coinciding with the cycle of the transition back to IDLE SHALL count as overrun (FSM is not IDLE in that cycle).
REQ-024 Watchdog: in AMP, ADC_WAIT, DAC_A and DAC_B a counter SHALL count cycles in the state; reaching 4095 without the done pulse SHALL set timeout, drop all requests and return to IDLE without updating samples or gain_cur.
REQ-025 Done pulses arriving in a state that does not expect them SHALL be ignored.
REQ-026 enable deassertion SHALL NOT abort a sequence in progress; it only stops new ticks.
REQ-027 A change of period SHALL take effect at the next wrap; if count >= new P-1, tick SHALL fire on the next cycle and the counter wraps to 0.

Reset
REQ-028 While RST = 1 on a clock edge: FSM = IDLE, tick counter = 0, watchdog = 0, gain_cur = 0, sample_va = sample_vb = 0, dac_data = 0, amp_gain = 0, and all request, pulse and flag outputs = 0, spi_owner = 00.
REQ-029 RST mid-sequence SHALL abort immediately; the next tick after release SHALL start a fresh sequence.

Verification
REQ-030 period=100, gain_in=0, enable=1, done pulses 5 cycles after each request -> AMP skipped, adc_start every 100 cycles, spi_owner sequence 10,11,00.
REQ-031 gain_in=0x11 -> first sequence enters AMP with amp_gain=0x11; the next sequence skips AMP; changing gain_in to 0x22 re-enters AMP once.
REQ-032 adc_data Va=14'h2000, Vb=0, dac_b_in=14'h1FFF -> dac_data 12'h000 for channel A, 12'hFFF for channel B, sample_valid one pulse.
REQ-033 period=10, ADC done delayed 30 cycles -> overrun=1, no extra adc_start pulses, sequence completes normally.
REQ-034 dac_done never arrives -> timeout=1 after 4095 cycles in DAC_A, dac_req=0, FSM IDLE, next tick starts a new sequence.
REQ-035 RST asserted in ADC_WAIT -> all outputs at reset values next cycle; adc_done arriving during or after reset is ignored.

Source files
------------

// File: rtl/sample_sequencer.sv
// Periodic sample sequencer: a tick counter starts preamp-gain / ADC-capture / two-channel
// DAC update sequences and arbitrates a shared SPI bus between the three drivers.
module sample_sequencer (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic        enable,
  input  logic [15:0] period,
  input  logic [7:0]  gain_in,
  output logic        amp_req,
  output logic [7:0]  amp_gain,
  input  logic        amp_done,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [27:0] adc_data,
  output logic        dac_req,
  output logic        dac_sel,
  output logic [11:0] dac_data,
  input  logic        dac_done,
  input  logic [13:0] dac_b_in,
  output logic [1:0]  spi_owner,
  output logic [13:0] sample_va,
  output logic [13:0] sample_vb,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: amp_req/dac_req are levels held until the matching one-cycle *_done
  // pulse is seen in the state that expects it; adc_start is a single-cycle pulse
  // answered later by a one-cycle adc_done. Done pulses in any other state are ignored.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_AMP      = 3'd1,
    S_CONV     = 3'd2,
    S_ADC_WAIT = 3'd3,
    S_DAC_A    = 3'd4,
    S_DAC_B    = 3'd5
  } state_t;

  // Last watchdog value before expiry: the 4095th cycle spent waiting in a state.
  localparam logic [11:0] WD_LIMIT = 12'd4094;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] wd_q, wd_d;
  logic [7:0]  gain_cur_q, gain_cur_d;
  logic [7:0]  amp_gain_q, amp_gain_d;
  logic [13:0] dac_b_q, dac_b_d;
  logic [13:0] va_q, va_d;
  logic [13:0] vb_q, vb_d;
  logic        sv_q, sv_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;

  logic [15:0] p_eff;
  logic        tick;
  logic        wd_expired;

  // Comparing with >= lets a shortened period wrap on the very next cycle.
  assign p_eff      = (period < 16'd2) ? 16'd2 : period;
  assign tick       = enable && (cnt_q >= (p_eff - 16'd1));
  assign wd_expired = (wd_q == WD_LIMIT);

  always_comb begin
    if (!enable || tick) cnt_d = 16'd0;
    else                 cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    state_d    = state_q;
    wd_d       = 12'd0;
    gain_cur_d = gain_cur_q;
    amp_gain_d = amp_gain_q;
    dac_b_d    = dac_b_q;
    va_d       = va_q;
    vb_d       = vb_q;
    sv_d       = 1'b0;
    timeout_d  = timeout_q;
    overrun_d  = overrun_q | (tick && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          if (gain_in != gain_cur_q) begin
            state_d    = S_AMP;
            amp_gain_d = gain_in;
          end else begin
            state_d = S_CONV;
          end
        end
      end
      S_AMP: begin
        if (amp_done) begin
          gain_cur_d = amp_gain_q;
          state_d    = S_CONV;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 12'd1;
        end
      end
      S_CONV: state_d = S_ADC_WAIT;
      S_ADC_WAIT: begin
        if (adc_done) begin
          va_d    = adc_data[27:14];
          vb_d    = adc_data[13:0];
          sv_d    = 1'b1;
          state_d = S_DAC_A;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 12'd1;
        end
      end
      S_DAC_A: begin
        if (dac_done) begin
          dac_b_d = dac_b_in;
          state_d = S_DAC_B;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 12'd1;
        end
      end
      S_DAC_B: begin
        if (dac_done) begin
          state_d = S_IDLE;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      wd_q       <= 12'd0;
      gain_cur_q <= 8'd0;
      amp_gain_q <= 8'd0;
      dac_b_q    <= 14'd0;
      va_q       <= 14'd0;
      vb_q       <= 14'd0;
      sv_q       <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      gain_cur_q <= gain_cur_d;
      amp_gain_q <= amp_gain_d;
      dac_b_q    <= dac_b_d;
      va_q       <= va_d;
      vb_q       <= vb_d;
      sv_q       <= sv_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  // Bus outputs are pure decodes of the state register, so only one driver can ever be granted.
  always_comb begin
    amp_req   = (state_q == S_AMP);
    adc_start = (state_q == S_CONV);
    dac_req   = (state_q == S_DAC_A) || (state_q == S_DAC_B);
    dac_sel   = (state_q == S_DAC_B);
    dac_data  = 12'd0;
    spi_owner = 2'b00;
    case (state_q)
      S_AMP:      spi_owner = 2'b01;
      S_CONV:     spi_owner = 2'b10;
      S_ADC_WAIT: spi_owner = 2'b10;
      S_DAC_A: begin
        spi_owner = 2'b11;
        dac_data  = {~va_q[13], va_q[12:2]};
      end
      S_DAC_B: begin
        spi_owner = 2'b11;
        dac_data  = {~dac_b_q[13], dac_b_q[12:2]};
      end
      default: spi_owner = 2'b00;
    endcase
  end

  assign amp_gain     = amp_gain_q;
  assign sample_va    = va_q;
  assign sample_vb    = vb_q;
  assign sample_valid = sv_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Self-checking bench for sample_sequencer: transaction-level reference model feeds an
// expected-event queue; a negedge monitor pops and compares every bus transaction.
module tb_sample_sequencer;

  logic        CLK_50M = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd100;
  logic [7:0]  gain_in = 8'd0;
  logic        amp_req;
  logic [7:0]  amp_gain;
  logic        amp_done = 1'b0;
  logic        adc_start;
  logic        adc_done;
  logic        adc_done_r = 1'b0;
  logic        adc_kick = 1'b0;
  logic [27:0] adc_data = 28'd0;
  logic        dac_req;
  logic        dac_sel;
  logic [11:0] dac_data;
  logic        dac_done = 1'b0;
  logic [13:0] dac_b_in = 14'd0;
  logic [1:0]  spi_owner;
  logic [13:0] sample_va;
  logic [13:0] sample_vb;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic        timeout;
  logic [2:0]  dbg_state;

  assign adc_done = adc_done_r | adc_kick;

  sample_sequencer dut (
    .CLK_50M(CLK_50M), .RST(RST), .enable(enable), .period(period), .gain_in(gain_in),
    .amp_req(amp_req), .amp_gain(amp_gain), .amp_done(amp_done),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .dac_req(dac_req), .dac_sel(dac_sel), .dac_data(dac_data), .dac_done(dac_done),
    .dac_b_in(dac_b_in), .spi_owner(spi_owner), .sample_va(sample_va), .sample_vb(sample_vb),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun), .timeout(timeout),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #10 CLK_50M = ~CLK_50M;

  int cyc = 0;
  always @(posedge CLK_50M) cyc++;

  initial begin
    #(20 * 90000);
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int start_t[$];
  logic [7:0] gain_cur_m = 8'd0;
  logic [2:0] idle_code = 3'd0;
  logic idle_known = 1'b0;

  int amp_lat = 4, adc_lat = 4, dac_lat = 4;
  logic dac_mute = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_event(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected act=%h exp=none (t=%0t)", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // ---------------- peripheral responders ----------------
  int amp_cnt = 0, dac_cnt = 0, adc_wait = 0;
  logic adc_armed = 1'b0;

  always @(negedge CLK_50M) begin
    amp_done = 1'b0;
    if (amp_req) begin
      if (amp_cnt >= amp_lat) begin amp_done = 1'b1; amp_cnt = 0; end
      else amp_cnt++;
    end else amp_cnt = 0;
  end

  always @(negedge CLK_50M) begin
    dac_done = 1'b0;
    if (dac_req && !dac_mute) begin
      if (dac_cnt >= dac_lat) begin dac_done = 1'b1; dac_cnt = 0; end
      else dac_cnt++;
    end else dac_cnt = 0;
  end

  always @(negedge CLK_50M) begin
    adc_done_r = 1'b0;
    if (adc_start) begin
      adc_armed = 1'b1;
      adc_wait  = adc_lat;
    end else if (adc_armed) begin
      if (adc_wait <= 1) begin adc_done_r = 1'b1; adc_armed = 1'b0; end
      else adc_wait--;
    end
  end

  // ---------------- monitor ----------------
  logic prev_amp = 1'b0, prev_dac = 1'b0, prev_sel = 1'b0;

  always @(negedge CLK_50M) begin
    logic [1:0] exp_owner;
    int nreq;
    if (!RST) begin
      if (amp_req && !prev_amp) mon_event("amp_txn", {4'd1, 20'd0, amp_gain});
      if (adc_start) begin
        mon_event("adc_start", {4'd2, 28'd0});
        start_t.push_back(cyc);
      end
      if (sample_valid) mon_event("sample", {4'd3, sample_va, sample_vb});
      if (dac_req && (!prev_dac || (prev_sel != dac_sel)))
        mon_event(dac_sel ? "dac_b_txn" : "dac_a_txn", {(dac_sel ? 4'd5 : 4'd4), 16'd0, dac_data});
      exp_owner = amp_req ? 2'b01 : dac_req ? 2'b11 : busy ? 2'b10 : 2'b00;
      check("spi_owner", {30'd0, spi_owner}, {30'd0, exp_owner});
      nreq = int'(amp_req) + int'(adc_start) + int'(dac_req);
      check("req_exclusive", {31'd0, (nreq > 1)}, 32'd0);
      if (idle_known) check("busy_vs_state", {31'd0, busy}, {31'd0, (dbg_state != idle_code)});
    end
    prev_amp = amp_req;
    prev_dac = dac_req;
    prev_sel = dac_sel;
  end

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [11:0] off_code(input logic [13:0] x);
    int v;
    v = (int'($signed(x)) + 8192) / 4;
    return v[11:0];
  endfunction

  task automatic push_seq(input logic [7:0] g, input logic [13:0] va, input logic [13:0] vb,
                          input logic [13:0] b);
    if (g != gain_cur_m) begin
      exp_q.push_back({4'd1, 20'd0, g});
      gain_cur_m = g;
    end
    exp_q.push_back({4'd2, 28'd0});
    exp_q.push_back({4'd3, va, vb});
    exp_q.push_back({4'd4, 16'd0, off_code(va)});
    exp_q.push_back({4'd5, 16'd0, off_code(b)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input int bound, output int n);
    n = 0;
    do begin @(negedge CLK_50M); n++; end while (!busy && n < bound);
    if (!busy) check("busy_rise_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin @(negedge CLK_50M); n++; end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_seq(input logic [15:0] per, input logic [7:0] g, input logic [13:0] va,
                         input logic [13:0] vb, input logic [13:0] b);
    int n;
    int exp_lat;
    period   = per;
    gain_in  = g;
    adc_data = {va, vb};
    dac_b_in = b;
    push_seq(g, va, vb, b);
    exp_lat = (per < 16'd2) ? 2 : int'(per);
    enable = 1'b1;
    wait_busy(2000, n);
    check("tick_latency", n, exp_lat);
    enable = 1'b0;
    wait_idle(20000);
    @(negedge CLK_50M);
    check("seq_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int ncyc);
    RST = 1'b1;
    repeat (ncyc) @(negedge CLK_50M);
    RST = 1'b0;
    gain_cur_m = 8'd0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_owner", {30'd0, spi_owner}, 32'd0);
    check("rst_amp_req", {31'd0, amp_req}, 32'd0);
    check("rst_adc_start", {31'd0, adc_start}, 32'd0);
    check("rst_dac_req", {31'd0, dac_req}, 32'd0);
    check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_sample_va", {18'd0, sample_va}, 32'd0);
    check("rst_sample_vb", {18'd0, sample_vb}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_amp_gain", {24'd0, amp_gain}, 32'd0);
    check("rst_dac_data", {20'd0, dac_data}, 32'd0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    int cnt_req;
    logic [7:0] g;
    logic [15:0] per;

    RST = 1'b1;
    repeat (4) @(negedge CLK_50M);
    check_reset_outputs();
    idle_code  = dbg_state;
    idle_known = 1'b1;
    RST = 1'b0;
    gain_cur_m = 8'd0;
    @(negedge CLK_50M);

    // Free-running ticks, gain unchanged: no AMP, adc_start every period.
    amp_lat = 4; adc_lat = 5; dac_lat = 4;
    period = 16'd100; gain_in = 8'd0;
    adc_data = {14'h0123, 14'h3ABC}; dac_b_in = 14'h0456;
    repeat (3) push_seq(8'd0, 14'h0123, 14'h3ABC, 14'h0456);
    start_t.delete();
    enable = 1'b1;
    n = 0;
    while (start_t.size() < 3 && n < 1000) begin @(negedge CLK_50M); n++; end
    enable = 1'b0;
    wait_idle(1000);
    @(negedge CLK_50M);
    check("start_count", start_t.size(), 3);
    if (start_t.size() >= 3) begin
      check("start_spacing1", start_t[1] - start_t[0], 100);
      check("start_spacing2", start_t[2] - start_t[1], 100);
    end
    check("phase_a_drained", exp_q.size(), 0);

    // Gain changes: AMP only when the requested gain differs from the applied one.
    run_seq(16'd40, 8'h11, 14'h0ABC, 14'h1234, 14'h3000);
    run_seq(16'd40, 8'h11, 14'h1FFF, 14'h2000, 14'h0001);
    run_seq(16'd40, 8'h22, 14'h3FFF, 14'h0000, 14'h2001);
    check("amp_gain_hold", {24'd0, amp_gain}, 32'h22);

    // Full-scale corners of the offset-binary conversion.
    run_seq(16'd50, 8'h22, 14'h2000, 14'h0000, 14'h1FFF);
    check("corner_va", {18'd0, sample_va}, 32'h2000);
    check("corner_vb", {18'd0, sample_vb}, 32'h0000);

    // Randomised sequences, including the degenerate periods 0 and 1.
    for (int i = 0; i < 12; i++) begin
      amp_lat = $urandom_range(0, 10);
      adc_lat = $urandom_range(0, 10);
      dac_lat = $urandom_range(0, 10);
      per = (i == 0) ? 16'd0 : (i == 1) ? 16'd1 : 16'($urandom_range(20, 300));
      g = ($urandom_range(0, 2) == 0) ? gain_cur_m : 8'($urandom_range(0, 255));
      run_seq(per, g, 14'($urandom), 14'($urandom), 14'($urandom));
    end
    check("overrun_quiet", {31'd0, overrun}, 32'd0);
    check("timeout_quiet", {31'd0, timeout}, 32'd0);

    // Slow ADC with short period: ticks during the sequence are dropped.
    amp_lat = 2; adc_lat = 30; dac_lat = 2;
    period = 16'd10;
    adc_data = {14'h0555, 14'h2AAA}; dac_b_in = 14'h1555;
    push_seq(gain_in, 14'h0555, 14'h2AAA, 14'h1555);
    enable = 1'b1;
    wait_busy(100, n);
    repeat (15) @(negedge CLK_50M);
    enable = 1'b0;
    wait_idle(1000);
    @(negedge CLK_50M);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_drained", exp_q.size(), 0);

    // DAC never answers: watchdog fires after 4095 cycles in DAC_A.
    amp_lat = 3; adc_lat = 3; dac_lat = 3;
    dac_mute = 1'b1;
    period = 16'd60;
    adc_data = {14'h0777, 14'h0888}; dac_b_in = 14'h0999;
    push_seq(gain_in, 14'h0777, 14'h0888, 14'h0999);
    void'(exp_q.pop_back());
    enable = 1'b1;
    wait_busy(200, n);
    enable = 1'b0;
    n = 0; cnt_req = 0;
    while (!timeout && n < 6000) begin
      @(negedge CLK_50M);
      n++;
      if (dac_req) cnt_req++;
    end
    check("timeout_set", {31'd0, timeout}, 32'd1);
    check("timeout_dac_cycles", cnt_req, 4095);
    check("timeout_dac_req", {31'd0, dac_req}, 32'd0);
    check("timeout_idle", {31'd0, busy}, 32'd0);
    check("timeout_drained", exp_q.size(), 0);
    dac_mute = 1'b0;
    run_seq(16'd30, gain_in, 14'h0100, 14'h3F00, 14'h2222);
    check("timeout_sticky", {31'd0, timeout}, 32'd1);

    // Reset while waiting for the ADC; the late adc_done pulses must not land.
    adc_lat = 8;
    period = 16'd20;
    exp_q.push_back({4'd2, 28'd0});
    enable = 1'b1;
    wait_busy(100, n);
    enable = 1'b0;
    repeat (3) @(negedge CLK_50M);
    RST = 1'b1;
    @(negedge CLK_50M);
    check_reset_outputs();
    do_reset(10);
    check("rst_drained", exp_q.size(), 0);
    @(negedge CLK_50M);
    adc_kick = 1'b1;
    @(negedge CLK_50M);
    adc_kick = 1'b0;
    repeat (3) @(negedge CLK_50M);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_va", {18'd0, sample_va}, 32'd0);
    adc_lat = 4; dac_lat = 4; amp_lat = 4;
    run_seq(16'd25, 8'h33, 14'h1ABC, 14'h2DEF, 14'h0F0F);

    repeat (5) @(negedge CLK_50M);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
